// File: rtl/ram_n_sweep.sv
// ram_n_sweep -- word-addressable RAM (2**ADDR_W x WIDTH) with a clear engine.
//
// Hack RAM semantics: clocked write, combinational read. A reset, or a
// clear request while idle, starts a sweep. The sweep writes INIT_VAL into
// one word per cycle, starting at word 0 and ending at word DEPTH-1. While
// the sweep runs, busy is high and out is forced to zero.
//
// Parameters:
//   WIDTH    data word width in bits (>=1)
//   ADDR_W   address width, DEPTH = 2**ADDR_W (1..14)
//   INIT_VAL value written to every word by a sweep
//
// Ports:
//   clk      in   1       rising-edge clock
//   reset    in   1       synchronous, active-high; starts a sweep
//   load     in   1       write enable, in -> mem[address] (idle only)
//   address  in   ADDR_W  read/write address
//   in       in   WIDTH   write data
//   clear    in   1       request to re-run the sweep (idle only)
//   out      out  WIDTH   mem[address], or 0 while busy
//   busy     out  1       high while a sweep is in progress
module ram_n_sweep #(
  parameter int unsigned       WIDTH    = 16,
  parameter int unsigned       ADDR_W   = 3,
  parameter logic [WIDTH-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  in,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                last;

  // One shared write port. The sweep and user loads are mutually exclusive.
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [WIDTH-1:0]    wdata;

  logic [WIDTH-1:0]    mem_q [DEPTH];

  assign last = (ptr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we      = 1'b0;
    waddr   = address;
    wdata   = in;

    unique case (state_q)
      SWEEP: begin
        // load and clear are ignored while sweeping.
        we    = 1'b1;
        waddr = ptr_q;
        wdata = INIT_VAL;
        if (last) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d   = ptr_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        // clear wins over load; the load in the same cycle is dropped.
        if (clear) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end else if (load) begin
          we = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase

    // Reset restarts the sweep from word 0 and suppresses any write this cycle.
    if (reset) begin
      we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SWEEP;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The array has no reset; the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign busy = (state_q == SWEEP);
  assign out  = busy ? '0 : mem_q[address];

endmodule

// File: tb/tb_ram_n_sweep.sv
module tb_ram_n_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration: 16 bits x 8 words, INIT_VAL 0.
  logic        a_reset = 1'b1;
  logic        a_load  = 1'b0;
  logic [2:0]  a_addr  = '0;
  logic [15:0] a_in    = '0;
  logic        a_clear = 1'b0;
  logic [15:0] a_out;
  logic        a_busy;

  // Variant: 8 bits x 16 words, INIT_VAL 8'h5A.
  logic        b_reset = 1'b1;
  logic        b_load  = 1'b0;
  logic [3:0]  b_addr  = '0;
  logic [7:0]  b_in    = '0;
  logic        b_clear = 1'b0;
  logic [7:0]  b_out;
  logic        b_busy;

  ram_n_sweep #(.WIDTH(16), .ADDR_W(3), .INIT_VAL(16'h0000)) dut_a (
    .clk(clk), .reset(a_reset), .load(a_load), .address(a_addr),
    .in(a_in), .clear(a_clear), .out(a_out), .busy(a_busy)
  );

  ram_n_sweep #(.WIDTH(8), .ADDR_W(4), .INIT_VAL(8'h5A)) dut_b (
    .clk(clk), .reset(b_reset), .load(b_load), .address(b_addr),
    .in(b_in), .clear(b_clear), .out(b_out), .busy(b_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busy high, also checking out is 0 throughout.
  // Optionally issues a load to dut_a at a given busy cycle.
  task automatic a_count_busy(output int n, input int load_at, input logic [2:0] la,
                              input logic [15:0] ld);
    n = 0;
    while (a_busy && n < 40) begin
      check("a_out_zero_in_sweep", 32'(a_out), 32'h0);
      if (n == load_at) begin
        a_load = 1'b1; a_addr = la; a_in = ld;
      end
      n++;
      tick();
      a_load = 1'b0;
    end
  endtask

  task automatic b_count_busy(output int n);
    n = 0;
    while (b_busy && n < 60) begin
      n++;
      tick();
    end
  endtask

  task automatic a_write(input logic [2:0] ad, input logic [15:0] d);
    a_load = 1'b1; a_addr = ad; a_in = d;
    tick();
    a_load = 1'b0;
  endtask

  task automatic a_read(input string tag, input logic [2:0] ad, input logic [15:0] exp);
    a_addr = ad;
    #1;
    check(tag, 32'(a_out), 32'(exp));
  endtask

  initial begin
    int n;

    // 1. Reset sweep timing
    tick();
    check("a_busy_in_reset", 32'(a_busy), 32'h1);
    check("a_out_in_reset", 32'(a_out), 32'h0);
    tick();
    a_reset = 1'b0;
    check("a_busy_after_reset", 32'(a_busy), 32'h1);
    a_count_busy(n, -1, 3'd0, 16'h0);
    check("a_reset_sweep_len", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) a_read("a_post_reset_zero", 3'(i), 16'h0000);

    // 2. Write/read; same-cycle read returns old value
    a_load = 1'b1; a_addr = 3'd5; a_in = 16'hBEEF;
    #1;
    check("a_old_value_same_cycle", 32'(a_out), 32'h0);
    tick();
    a_load = 1'b0;
    check("a_beef_next_cycle", 32'(a_out), 32'hBEEF);
    for (int i = 0; i < 8; i++)
      if (i != 5) a_read("a_others_zero", 3'(i), 16'h0000);

    // 3. Runtime clear, with a late load during busy to addr 2
    for (int i = 0; i < 8; i++) a_write(3'(i), 16'h1111 * 16'(i + 1));
    for (int i = 0; i < 8; i++) a_read("a_fill_readback", 3'(i), 16'h1111 * 16'(i + 1));
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    a_count_busy(n, 5, 3'd2, 16'hDEAD);
    check("a_clear_sweep_len", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) a_read("a_post_clear_zero", 3'(i), 16'h0000);

    // 4. clear and load in the same cycle: clear wins
    a_write(3'd3, 16'h1234);
    a_clear = 1'b1; a_load = 1'b1; a_addr = 3'd3; a_in = 16'hAAAA;
    tick();
    a_clear = 1'b0; a_load = 1'b0;
    check("a_prio_busy", 32'(a_busy), 32'h1);
    a_count_busy(n, -1, 3'd0, 16'h0);
    check("a_prio_sweep_len", 32'(n), 32'd8);
    a_read("a_prio_addr3", 3'd3, 16'h0000);

    // 5. Reset at sweep cycle 4 restarts the full sweep
    a_write(3'd7, 16'h7777);
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("a_mid_busy", 32'(a_busy), 32'h1);
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    check("a_rst_mid_busy", 32'(a_busy), 32'h1);
    a_count_busy(n, -1, 3'd0, 16'h0);
    check("a_rst_mid_sweep_len", 32'(n), 32'd8);
    a_read("a_rst_mid_addr7", 3'd7, 16'h0000);

    // 6. Parameter variant
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    check("b_busy_after_reset", 32'(b_busy), 32'h1);
    check("b_out_in_sweep", 32'(b_out), 32'h0);
    b_count_busy(n);
    check("b_sweep_len", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      b_addr = 4'(i);
      #1;
      check("b_init_5a", 32'(b_out), 32'h5A);
    end
    b_load = 1'b1; b_addr = 4'd15; b_in = 8'hC3;
    tick();
    b_load = 1'b0;
    check("b_addr15_write", 32'(b_out), 32'hC3);
    b_addr = 4'd14;
    #1;
    check("b_addr14_kept", 32'(b_out), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
